// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the RAM port arbiter.
package ram_arb_pkg;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned ID_WIDTH       = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic                      wr_rd;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] din;
    logic [ID_WIDTH-1:0]       id;
  } cmd_t;

  // Requester index after id, wrapping at n.
  function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] id,
                                                  input int unsigned n);
    if (32'(id) + 32'd1 >= n) return '0;
    return id + ID_WIDTH'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [IDX_W-1:0]   idx_c,
  output logic               any_c
);

  int              c;
  logic [IDX_W-1:0] ci;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    c       = 0;
    ci      = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      c = int'(ptr) + i;
      if (c >= int'(NUM_REQ)) c = c - int'(NUM_REQ);
      ci = IDX_W'(c);
      if (!any_c && req[ci]) begin
        grant_c[ci] = 1'b1;
        idx_c       = ci;
        any_c       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing a single-port RAM between NUM_REQ requesters.
// Optional BUSY timeout enabled by defining RAM_ARB_TIMEOUT_EN.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
`ifdef RAM_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_wr_rd,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         rsp_dout,
  output logic                          rsp_error,
  output logic                          ram_en,
  output logic                          ram_wr_rd,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_din,
  output logic                          ram_valid,
  input  logic [DATA_WIDTH-1:0]         ram_dout,
  input  logic                          ram_ready,
  input  logic                          ram_error
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_e                 state_q, state_n;
  cmd_t                   cmd_q, cmd_n;
  logic [IDX_W-1:0]       ptr_q, ptr_n;
  logic [NUM_REQ-1:0]     gnt_n, done_n;
  logic                   act_q, act_n;
  logic [DATA_WIDTH-1:0]  rsp_dout_n;
  logic                   rsp_error_n;

  logic [NUM_REQ-1:0]     pick_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]       cnt_q, cnt_n;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req),
    .ptr     (ptr_q),
    .grant_c (pick_grant),
    .idx_c   (pick_idx),
    .any_c   (pick_any)
  );

  // Latched command drives the RAM side directly; en/valid track BUSY.
  assign ram_en    = act_q;
  assign ram_valid = act_q;
  assign ram_wr_rd = cmd_q.wr_rd;
  assign ram_addr  = ADDR_WIDTH'(cmd_q.addr);
  assign ram_din   = DATA_WIDTH'(cmd_q.din);

  always_comb begin
    state_n     = state_q;
    cmd_n       = cmd_q;
    ptr_n       = ptr_q;
    gnt_n       = '0;
    done_n      = '0;
    act_n       = 1'b0;
    rsp_dout_n  = rsp_dout;
    rsp_error_n = rsp_error;
`ifdef RAM_ARB_TIMEOUT_EN
    cnt_n       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          cmd_n.wr_rd = req_wr_rd[pick_idx];
          cmd_n.addr  = DEF_ADDR_WIDTH'(req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH]);
          cmd_n.din   = DEF_DATA_WIDTH'(req_din[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH]);
          cmd_n.id    = ID_WIDTH'(pick_idx);
          gnt_n       = pick_grant;
          act_n       = 1'b1;
          state_n     = BUSY;
`ifdef RAM_ARB_TIMEOUT_EN
          cnt_n       = '0;
`endif
        end
      end
      BUSY: begin
        act_n = 1'b1;
        if (ram_ready) begin
          rsp_dout_n  = cmd_q.wr_rd ? '0 : ram_dout;
          rsp_error_n = ram_error;
          done_n      = NUM_REQ'(1) << cmd_q.id;
          ptr_n       = IDX_W'(next_id(cmd_q.id, NUM_REQ));
          act_n       = 1'b0;
          state_n     = RESP;
        end
`ifdef RAM_ARB_TIMEOUT_EN
        // Give up after TIMEOUT_CYCLES BUSY cycles and report an error.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_dout_n  = '0;
          rsp_error_n = 1'b1;
          done_n      = NUM_REQ'(1) << cmd_q.id;
          ptr_n       = IDX_W'(next_id(cmd_q.id, NUM_REQ));
          act_n       = 1'b0;
          state_n     = RESP;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      ptr_q     <= '0;
      act_q     <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      rsp_dout  <= '0;
      rsp_error <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_n;
      cmd_q     <= cmd_n;
      ptr_q     <= ptr_n;
      act_q     <= act_n;
      gnt       <= gnt_n;
      done      <= done_n;
      rsp_dout  <= rsp_dout_n;
      rsp_error <= rsp_error_n;
`ifdef RAM_ARB_TIMEOUT_EN
      cnt_q     <= cnt_n;
`endif
    end
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Round-robin arbiter that shares the single-port RAM between NUM_REQ requesters.
- Latches one requester's command and drives the RAM en/valid/ready handshake until the RAM responds.
- Returns read data and error to the winning requester.
- Sits between bus-side masters and the single-port RAM in the memory subsystem.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 8, RAM address width
DATA_WIDTH, 32, RAM data width

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  synchronous active-low reset
req  input  NUM_REQ  per-requester request, level
req_wr_rd  input  NUM_REQ  per-requester 1=write, 0=read
req_addr  input  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i at slice i
req_din  input  NUM_REQ*DATA_WIDTH  flattened write data
gnt  output  NUM_REQ  one-hot, one-cycle pulse when command latched
done  output  NUM_REQ  one-hot, one-cycle pulse at completion
rsp_dout  output  DATA_WIDTH  read data, valid with done
rsp_error  output  1  error, valid with done
ram_en  output  1  RAM enable
ram_wr_rd  output  1  RAM write/read select
ram_addr  output  ADDR_WIDTH  RAM address
ram_din  output  DATA_WIDTH  RAM write data
ram_valid  output  1  command valid to RAM
ram_dout  input  DATA_WIDTH  RAM read data
ram_ready  input  1  RAM completion strobe
ram_error  input  1  RAM error, sampled with ram_ready

Behaviour:
Reset
- Sampled on clk rising edge while rstn=0.
- All outputs go to 0; state=IDLE; priority pointer=0.
- Reset mid-transaction abandons the command: no done is issued, and ram_en/ram_valid are 0 after that edge.

FSM: IDLE, BUSY, RESP.
- IDLE: if any req bit is set, pick the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Latch wr_rd, addr and din of the winner.
  - Next edge: gnt[winner]=1 for one cycle; state=BUSY.
  - No request: stay IDLE.
- BUSY: ram_en=1 and ram_valid=1; latched command held stable on ram_* outputs.
  - ram_ready=1: capture ram_dout (reads only; writes return 0) and ram_error; state=RESP.
  - ram_ready=0: stay BUSY indefinitely unless the optional timeout is compiled in.
- RESP: ram_en=0, ram_valid=0; done[winner]=1 for one cycle; rsp_dout/rsp_error driven.
  - Pointer=winner+1 mod NUM_REQ.
  - Next state=IDLE.

Latency and throughput
- req sampled in IDLE at edge N: gnt at N+1, RAM command from N+1.
- ram_ready at edge M: done at M+1.
- Next grant earliest at M+2.
- Minimum 3 cycles per transaction.

Requester rules
- Requester must hold its command stable until gnt.
- req still high in a later IDLE cycle = a new transaction.
- req changes while another requester is granted are ignored until IDLE.
- rsp_dout and rsp_error hold their values until the next RESP.

Boundary conditions
- All requesters active: strict rotation 0,1,2,3,0…
- Single requester: served back-to-back.
- ram_ready while not BUSY: ignored.
- gnt and done are never asserted together, and never for more than one requester at a time.

Optional Feature:
Macro: RAM_ARB_TIMEOUT_EN
- Defined: parameter TIMEOUT_CYCLES (default 64) is added.
  - A cycle counter runs in BUSY.
  - If TIMEOUT_CYCLES cycles elapse without ram_ready, go to RESP with rsp_error=1 and rsp_dout=0.
  - The pointer advances as normal.
- Undefined: no counter; BUSY waits for ram_ready forever.

Decomposition:
- Package ram_arb_pkg holds:
  - state enum typedef (IDLE, BUSY, RESP)
  - default width constants
  - latched-command struct typedef {wr_rd, addr, din, id}
- One sub-module: rr_arbiter (combinational round-robin pick from req and pointer, returns one-hot grant plus index).

Test Plan:
- Single read: req[0]=1 with addr=0x10; RAM returns ready 2 cycles after valid with dout=0xDEADBEEF -> gnt[0] at N+1, done[0] with rsp_dout=0xDEADBEEF, rsp_error=0.
- Write: req[2] write with addr=0x05, din=0x12345678 -> ram_wr_rd=1, ram_addr=0x05, ram_din=0x12345678 held until ready; done[2] with rsp_dout=0.
- Fairness: all four req held for 8 transactions with pointer=0 -> grant order 0,1,2,3,0,1,2,3; no requester granted twice in a row.
- Error path: RAM answers ready with ram_error=1 for addr=0xFF -> done with rsp_error=1; the next transaction has rsp_error=0.
- Reset mid-op: rstn=0 during BUSY -> after that edge ram_en=0, no done, pointer=0; after rstn=1, req[1] is granted first.
- Timeout (macro defined, TIMEOUT_CYCLES=16): ram_ready never asserted -> done after 16 BUSY cycles with rsp_error=1.
